// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART frame receiver.
package uart_rx_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 32;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Per-frame line configuration captured when a start bit is accepted
  typedef struct packed {
    logic parity_enable;
    logic parity_type;
  } frame_cfg_t;

  // Expected parity bit for the received data word
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      parity_type);
    return (^data) ^ (parity_type == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit edge counter and sample-point decode. With UART_RX_MAJORITY_EN defined,
// each bit is the 2-of-3 vote around mid-bit and the decision moves one clk later.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      rx,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sample_strobe,
  output logic                      sampled_bit,
  output logic                      bit_end
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] half_cnt;

  assign half_cnt = prescale >> 1;
  assign bit_end  = run && (edge_cnt == (prescale - PRESCALE_WIDTH'(1)));

  // Counter idles at zero so every frame starts on a fresh bit boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt <= '0;
    end else if (!run || bit_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      early_q <= 2'b11;
    end else if (run && (edge_cnt == (half_cnt - PRESCALE_WIDTH'(1)))) begin
      early_q[0] <= rx;
    end else if (run && (edge_cnt == half_cnt)) begin
      early_q[1] <= rx;
    end
  end

  assign sample_strobe = run && (edge_cnt == (half_cnt + PRESCALE_WIDTH'(1)));
  assign sampled_bit   = (early_q[0] & early_q[1]) | (early_q[0] & rx) | (early_q[1] & rx);
`else
  assign sample_strobe = run && (edge_cnt == half_cnt);
  assign sampled_bit   = rx;
`endif

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// UART receiver: start/data/parity/stop deserializer with level valid flag for a
// downstream synchronizer. Optional macro UART_RX_MAJORITY_EN enables 3-sample voting.
module uart_rx_frame_receiver
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  logic rx_meta;
  logic rx;

  rx_state_t                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  frame_cfg_t                cfg_q, cfg_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      bad_q, bad_d;
  logic [DATA_WIDTH-1:0]     p_data_d;
  logic                      data_valid_d;
  logic                      parity_error_d;
  logic                      stop_error_d;

  logic sample_strobe;
  logic sampled_bit;
  logic bit_end;

  // Two-flop synchronizer; idles high like the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx      <= rx_meta;
    end
  end

  uart_rx_bit_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_sampler (
    .clk          (clk),
    .reset        (reset),
    .run          (state_q != IDLE),
    .rx           (rx),
    .prescale     (prescale_q),
    .sample_strobe(sample_strobe),
    .sampled_bit  (sampled_bit),
    .bit_end      (bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prescale_q   <= '0;
      cfg_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      bad_q        <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      cfg_q        <= cfg_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      bad_q        <= bad_d;
      p_data       <= p_data_d;
      data_valid   <= data_valid_d;
      parity_error <= parity_error_d;
      stop_error   <= stop_error_d;
    end
  end

  // Frame sequencing; error flags are single-cycle pulses, data/valid hold
  always_comb begin
    state_d        = state_q;
    prescale_d     = prescale_q;
    cfg_d          = cfg_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    bad_d          = bad_q;
    p_data_d       = p_data;
    data_valid_d   = data_valid;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d             = START;
          prescale_d          = prescale;
          cfg_d.parity_enable = parity_enable;
          cfg_d.parity_type   = parity_type;
          bad_d               = 1'b0;
          bit_cnt_d           = '0;
          data_valid_d        = 1'b0;
        end
      end
      START: begin
        if (sample_strobe && sampled_bit) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_strobe) begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
        if (bit_end && (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH))) begin
          state_d = cfg_q.parity_enable ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_strobe &&
            (sampled_bit != calc_parity(MAX_DATA_WIDTH'(shift_q), cfg_q.parity_type))) begin
          parity_error_d = 1'b1;
          bad_d          = 1'b1;
        end
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed
        if (sample_strobe) begin
          state_d = IDLE;
          if (!sampled_bit) begin
            stop_error_d = 1'b1;
          end else if (!bad_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Directed self-checking bench for uart_rx_frame_receiver.
module tb_uart_rx_frame_receiver;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned LAT = 81;
`else
  localparam int unsigned LAT = 80;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic          parity_enable;
  logic          parity_type;
  logic [PW-1:0] prescale;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_frame_receiver #(
    .DATA_WIDTH    (DW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .prescale     (prescale),
    .p_data       (p_data),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  // Event monitor: pulse counts and valid edges, sampled on the falling edge
  int unsigned   cyc = 0;
  int unsigned   pe_cnt = 0, se_cnt = 0, rise_cnt = 0, fall_cnt = 0, last_rise_cyc = 0;
  logic          dv_prev = 1'b0;
  logic [DW-1:0] rise_data [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (parity_error) pe_cnt <= pe_cnt + 1;
    if (stop_error)   se_cnt <= se_cnt + 1;
    if (data_valid && !dv_prev) begin
      rise_cnt                <= rise_cnt + 1;
      last_rise_cyc           <= cyc;
      rise_data[rise_cnt % 16] <= p_data;
    end
    if (!data_valid && dv_prev) fall_cnt <= fall_cnt + 1;
    dv_prev <= data_valid;
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (int'(prescale)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * int'(prescale)) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd8;
    repeat (3) @(negedge clk);
    checks++; if (p_data !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%0h exp=0", p_data); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%0b exp=0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_pe got=%0b exp=0", parity_error); end
    checks++; if (stop_error !== 1'b0) begin failures++; $display("FAIL reset_se got=%0b exp=0", stop_error); end
    reset = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_basic();
    int unsigned br, bp, bs, t0;
    prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    br = rise_cnt; bp = pe_cnt; bs = se_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    checks++; if (rise_cnt - br !== 1) begin failures++; $display("FAIL t1_rises got=%0d exp=1", rise_cnt - br); end
    checks++; if (last_rise_cyc - t0 !== LAT) begin failures++; $display("FAIL t1_latency got=%0d exp=%0d", last_rise_cyc - t0, LAT); end
    checks++; if (p_data !== 8'hA5) begin failures++; $display("FAIL t1_pdata got=%0h exp=a5", p_data); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL t1_dv got=%0b exp=1", data_valid); end
    checks++; if ((pe_cnt - bp) + (se_cnt - bs) !== 0) begin failures++; $display("FAIL t1_errs got=%0d exp=0", (pe_cnt - bp) + (se_cnt - bs)); end
  endtask

  task automatic test_parity();
    int unsigned br, bp, bs;
    prescale = 6'd16; parity_enable = 1'b1; parity_type = 1'b0;
    br = rise_cnt; bp = pe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    checks++; if (rise_cnt - br !== 1) begin failures++; $display("FAIL t2a_rises got=%0d exp=1", rise_cnt - br); end
    checks++; if (p_data !== 8'h3C) begin failures++; $display("FAIL t2a_pdata got=%0h exp=3c", p_data); end
    checks++; if (pe_cnt - bp !== 0) begin failures++; $display("FAIL t2a_pe got=%0d exp=0", pe_cnt - bp); end
    br = rise_cnt; bp = pe_cnt; bs = se_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    checks++; if (pe_cnt - bp !== 1) begin failures++; $display("FAIL t2b_pe got=%0d exp=1", pe_cnt - bp); end
    checks++; if (rise_cnt - br !== 0) begin failures++; $display("FAIL t2b_rises got=%0d exp=0", rise_cnt - br); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL t2b_dv got=%0b exp=0", data_valid); end
    checks++; if (p_data !== 8'h3C) begin failures++; $display("FAIL t2b_pdata got=%0h exp=3c", p_data); end
    checks++; if (se_cnt - bs !== 0) begin failures++; $display("FAIL t2b_se got=%0d exp=0", se_cnt - bs); end
  endtask

  task automatic test_stop_error();
    int unsigned br, bp, bs;
    prescale = 6'd32; parity_enable = 1'b0; parity_type = 1'b0;
    br = rise_cnt; bp = pe_cnt; bs = se_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    idle_bits(3);
    checks++; if (se_cnt - bs !== 1) begin failures++; $display("FAIL t3_se got=%0d exp=1", se_cnt - bs); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL t3_dv got=%0b exp=0", data_valid); end
    checks++; if (rise_cnt - br !== 0) begin failures++; $display("FAIL t3_rises got=%0d exp=0", rise_cnt - br); end
    checks++; if (pe_cnt - bp !== 0) begin failures++; $display("FAIL t3_pe got=%0d exp=0", pe_cnt - bp); end
    checks++; if (p_data !== 8'h3C) begin failures++; $display("FAIL t3_pdata got=%0h exp=3c", p_data); end
  endtask

  task automatic test_glitch();
    int unsigned br, bf, bp, bs;
    prescale = 6'd16;
    br = rise_cnt; bf = fall_cnt; bp = pe_cnt; bs = se_cnt;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    checks++; if ((pe_cnt - bp) + (se_cnt - bs) !== 0) begin failures++; $display("FAIL t4_errs got=%0d exp=0", (pe_cnt - bp) + (se_cnt - bs)); end
    checks++; if ((rise_cnt - br) + (fall_cnt - bf) !== 0) begin failures++; $display("FAIL t4_dv_edges got=%0d exp=0", (rise_cnt - br) + (fall_cnt - bf)); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL t4_dv got=%0b exp=0", data_valid); end
    checks++; if (p_data !== 8'h3C) begin failures++; $display("FAIL t4_pdata got=%0h exp=3c", p_data); end
  endtask

  task automatic test_back_to_back();
    int unsigned br, bf, bp, bs;
    prescale = 6'd8; parity_enable = 1'b1; parity_type = 1'b1;
    br = rise_cnt; bf = fall_cnt; bp = pe_cnt; bs = se_cnt;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1);
    send_frame(8'hEE, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    checks++; if (rise_cnt - br !== 2) begin failures++; $display("FAIL t5_rises got=%0d exp=2", rise_cnt - br); end
    checks++; if (fall_cnt - bf !== 1) begin failures++; $display("FAIL t5_falls got=%0d exp=1", fall_cnt - bf); end
    checks++; if (rise_data[br % 16] !== 8'h11) begin failures++; $display("FAIL t5_first got=%0h exp=11", rise_data[br % 16]); end
    checks++; if (rise_data[(br + 1) % 16] !== 8'hEE) begin failures++; $display("FAIL t5_second got=%0h exp=ee", rise_data[(br + 1) % 16]); end
    checks++; if (p_data !== 8'hEE) begin failures++; $display("FAIL t5_pdata got=%0h exp=ee", p_data); end
    checks++; if ((pe_cnt - bp) + (se_cnt - bs) !== 0) begin failures++; $display("FAIL t5_errs got=%0d exp=0", (pe_cnt - bp) + (se_cnt - bs)); end
  endtask

  task automatic test_reset_midframe();
    int unsigned br, bp, bs;
    prescale = 6'd16; parity_enable = 1'b0; parity_type = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (p_data !== 8'h00) begin failures++; $display("FAIL t6_rst_pdata got=%0h exp=0", p_data); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL t6_rst_dv got=%0b exp=0", data_valid); end
    checks++; if ({parity_error, stop_error} !== 2'b00) begin failures++; $display("FAIL t6_rst_errs got=%0b exp=0", {parity_error, stop_error}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_bits(2);
    br = rise_cnt; bp = pe_cnt; bs = se_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    checks++; if (p_data !== 8'h5A) begin failures++; $display("FAIL t6_pdata got=%0h exp=5a", p_data); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL t6_dv got=%0b exp=1", data_valid); end
    checks++; if (rise_cnt - br !== 1) begin failures++; $display("FAIL t6_rises got=%0d exp=1", rise_cnt - br); end
    checks++; if ((pe_cnt - bp) + (se_cnt - bs) !== 0) begin failures++; $display("FAIL t6_errs got=%0d exp=0", (pe_cnt - bp) + (se_cnt - bs)); end
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd8;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
